// File: rtl/imsic_msi_decoder.sv
// Purpose : decodes IMSIC seteipnum bus writes into {hart, file, id} MSI records and queues them.
// Latency : an accepted write is visible on o_msi_* one cycle later at the earliest.
// Backpress: o_wr_ready drops while the queue is full; o_msi_* holds until i_msi_ready.

// Purpose : generic synchronous FIFO with extra-bit pointers for full/empty.
// Latency : a pushed word is visible at the head one cycle after the push.
// Backpress: pushes are ignored when full, pops are ignored when empty.
module imsic_msi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  // Pointer update; natural binary wrap works because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

module imsic_msi_decoder #(
  parameter int          NR_HARTS    = 4,
  parameter int          NR_VS_FILES = 1,
  parameter int          NR_SRC      = 64,
  parameter logic [31:0] M_BASE      = 32'h2400_0000,
  parameter logic [31:0] S_BASE      = 32'h2800_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          HW          = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1,
  parameter int          FW          = $clog2(NR_VS_FILES + 2),
  parameter int          IW          = $clog2(NR_SRC)
) (
  input  logic          i_clk,
  input  logic          ni_rst,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [31:0]   i_wr_addr,
  input  logic [31:0]   i_wr_data,
  output logic          o_msi_valid,
  input  logic          i_msi_ready,
  output logic [HW-1:0] o_msi_hart,
  output logic [FW-1:0] o_msi_file,
  output logic [IW-1:0] o_msi_id,
  output logic [15:0]   o_drop_cnt
);

  typedef struct packed {
    logic [HW-1:0] hart;
    logic [FW-1:0] file;
    logic [IW-1:0] id;
  } msi_t;

  // Page counts and files-per-hart in the 20-bit page-number domain.
  localparam logic [19:0] M_PAGES        = 20'(NR_HARTS);
  localparam logic [19:0] FILES_PER_HART = 20'(NR_VS_FILES + 1);
  localparam logic [19:0] S_PAGES        = 20'(NR_HARTS * (NR_VS_FILES + 1));
  localparam logic [31:0] ID_LIMIT       = 32'(NR_SRC);

  logic [19:0] m_page;
  logic [19:0] s_page;
  logic [19:0] s_hart_full;
  logic [19:0] s_file_full;
  logic        m_hit;
  logic        s_hit;
  logic        off_le;
  logic        off_be;
  logic [31:0] id_raw;
  logic        id_ok;
  logic        wr_good;
  logic        wr_accept;
  msi_t        wr_entry;
  msi_t        head;
  logic        q_full;
  logic        q_empty;
  logic        deq;

  // Bases are 4 KiB aligned, so page numbers come from the upper 20 address bits;
  // an address below a base wraps to a huge page number and misses.
  assign m_page = i_wr_addr[31:12] - M_BASE[31:12];
  assign s_page = i_wr_addr[31:12] - S_BASE[31:12];
  assign m_hit  = (m_page < M_PAGES);
  assign s_hit  = (s_page < S_PAGES);

  assign s_hart_full = s_page / FILES_PER_HART;
  assign s_file_full = (s_page % FILES_PER_HART) + 20'd1;

  assign off_le = (i_wr_addr[11:0] == 12'h000);
  assign off_be = (i_wr_addr[11:0] == 12'h004);

  // Identity selection: little-endian register takes data as-is, big-endian byte-swaps it.
  always_comb begin
    id_raw = i_wr_data;
    if (off_be) begin
      id_raw = {i_wr_data[7:0], i_wr_data[15:8], i_wr_data[23:16], i_wr_data[31:24]};
    end
  end

  // The full 32-bit identity is range-checked so high garbage bits cannot alias a legal id.
  assign id_ok   = (id_raw != 32'd0) && (id_raw < ID_LIMIT);
  assign wr_good = (m_hit || s_hit) && (off_le || off_be) && id_ok;

  // Entry formation; the M window wins if both windows were ever configured to overlap.
  always_comb begin
    wr_entry      = '0;
    wr_entry.id   = IW'(id_raw);
    if (m_hit) begin
      wr_entry.hart = HW'(m_page);
      wr_entry.file = '0;
    end else begin
      wr_entry.hart = HW'(s_hart_full);
      wr_entry.file = FW'(s_file_full);
    end
  end

  // Ready depends only on queue state, so a full queue blocks even a same-cycle dequeue.
  assign o_wr_ready = !q_full;
  assign wr_accept  = i_wr_valid && !q_full;
  assign deq        = i_msi_ready && !q_empty;

  imsic_msi_fifo #(
    .WIDTH ($bits(msi_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (ni_rst),
    .push     (wr_accept && wr_good),
    .push_dat (wr_entry),
    .pop      (deq),
    .head_dat (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Head is masked so stale storage never leaks onto the outputs while idle.
  assign o_msi_valid = !q_empty;
  assign o_msi_hart  = q_empty ? '0 : head.hart;
  assign o_msi_file  = q_empty ? '0 : head.file;
  assign o_msi_id    = q_empty ? '0 : head.id;

  // Saturating count of writes that were accepted but carried nothing deliverable.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      o_drop_cnt <= '0;
    end else if (wr_accept && !wr_good && (o_drop_cnt != 16'hFFFF)) begin
      o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_imsic_msi_decoder.sv
// Bench for imsic_msi_decoder: directed vector table, full-queue and reset sequences,
// then randomized traffic against a queue-based reference model.
module tb_imsic_msi_decoder;

  localparam int          NR_HARTS    = 4;
  localparam int          NR_VS_FILES = 1;
  localparam int          NR_SRC      = 64;
  localparam logic [31:0] M_BASE      = 32'h2400_0000;
  localparam logic [31:0] S_BASE      = 32'h2800_0000;
  localparam int          FIFO_DEPTH  = 4;
  localparam int          HW          = 2;
  localparam int          FW          = 2;
  localparam int          IW          = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [31:0]   wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          msi_valid;
  logic          msi_ready = 1'b0;
  logic [HW-1:0] msi_hart;
  logic [FW-1:0] msi_file;
  logic [IW-1:0] msi_id;
  logic [15:0]   drop_cnt;

  int total = 0;
  int passed = 0;

  imsic_msi_decoder #(
    .NR_HARTS    (NR_HARTS),
    .NR_VS_FILES (NR_VS_FILES),
    .NR_SRC      (NR_SRC),
    .M_BASE      (M_BASE),
    .S_BASE      (S_BASE),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .i_clk       (clk),
    .ni_rst      (rst_n),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_msi_valid (msi_valid),
    .i_msi_ready (msi_ready),
    .o_msi_hart  (msi_hart),
    .o_msi_file  (msi_file),
    .o_msi_id    (msi_id),
    .o_drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] head_word();
    return (32'(msi_hart) << 16) | (32'(msi_file) << 8) | 32'(msi_id);
  endfunction

  // Reference decode computed from address windows with plain integer arithmetic.
  function automatic void ref_decode(input logic [31:0] addr, input logic [31:0] data,
                                     output bit ok, output int hart, output int file, output int id);
    longint a = longint'(addr);
    longint mb = longint'(M_BASE);
    longint sb = longint'(S_BASE);
    longint off = a % 4096;
    longint d = longint'(data);
    longint idv;
    bit hit = 0;
    hart = 0; file = 0;
    if (a >= mb && a < mb + NR_HARTS * 4096) begin
      hit = 1; hart = int'((a - mb) / 4096); file = 0;
    end else if (a >= sb && a < sb + NR_HARTS * (NR_VS_FILES + 1) * 4096) begin
      int q = int'((a - sb) / 4096);
      hit = 1; hart = q / (NR_VS_FILES + 1); file = q % (NR_VS_FILES + 1) + 1;
    end
    if (off == 4)
      idv = (d % 256) * 16777216 + ((d / 256) % 256) * 65536 + ((d / 65536) % 256) * 256 + (d / 16777216);
    else
      idv = d;
    id = int'(idv % NR_SRC);
    ok = hit && (off == 0 || off == 4) && idv != 0 && idv < NR_SRC;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        vld;
    logic [1:0]  hart;
    logic [1:0]  file;
    logic [5:0]  id;
    logic [15:0] drop;
  } vec_t;

  typedef struct {
    int hart;
    int file;
    int id;
  } ent_t;

  vec_t vecs[13];
  ent_t mq[$];

  initial begin
    int model_drop;
    // addr, data, expect valid, hart, file, id, cumulative drop count
    vecs[0]  = '{32'h2400_2000, 32'd5,         1'b1, 2'd2, 2'd0, 6'd5,  16'd0};
    vecs[1]  = '{32'h2800_3004, 32'h0700_0000, 1'b1, 2'd1, 2'd2, 6'd7,  16'd0};
    vecs[2]  = '{32'h2400_0000, 32'd0,         1'b0, 2'd0, 2'd0, 6'd0,  16'd1};
    vecs[3]  = '{32'h2400_0000, 32'd64,        1'b0, 2'd0, 2'd0, 6'd0,  16'd2};
    vecs[4]  = '{32'h2400_4000, 32'd1,         1'b0, 2'd0, 2'd0, 6'd0,  16'd3};
    vecs[5]  = '{32'h2400_0008, 32'd1,         1'b0, 2'd0, 2'd0, 6'd0,  16'd4};
    vecs[6]  = '{32'h2800_0000, 32'd63,        1'b1, 2'd0, 2'd1, 6'd63, 16'd4};
    vecs[7]  = '{32'h2800_7000, 32'd1,         1'b1, 2'd3, 2'd2, 6'd1,  16'd4};
    vecs[8]  = '{32'h2800_8000, 32'd1,         1'b0, 2'd0, 2'd0, 6'd0,  16'd5};
    vecs[9]  = '{32'h2400_3004, 32'h2A00_0000, 1'b1, 2'd3, 2'd0, 6'd42, 16'd5};
    vecs[10] = '{32'h2400_1004, 32'd5,         1'b0, 2'd0, 2'd0, 6'd0,  16'd6};
    vecs[11] = '{32'h23FF_F000, 32'd1,         1'b0, 2'd0, 2'd0, 6'd0,  16'd7};
    vecs[12] = '{32'h2400_0000, 32'h0001_0001, 1'b0, 2'd0, 2'd0, 6'd0,  16'd8};

    // Reset state
    #12;
    check("reset_valid", 32'(msi_valid), 32'd0);
    check("reset_head", head_word(), 32'd0);
    check("reset_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_wr_ready", 32'(wr_ready), 32'd1);

    // Directed vector table, consumer always ready
    msi_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      wr_addr = vecs[i].addr; wr_data = vecs[i].data; wr_valid = 1'b1;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(msi_valid), 32'(vecs[i].vld));
      check($sformatf("vec%0d_head", i), head_word(),
            (32'(vecs[i].hart) << 16) | (32'(vecs[i].file) << 8) | 32'(vecs[i].id));
      check($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].drop));
      @(posedge clk); #1;
    end

    // Full-queue sequence: four fill it, the fifth waits for the first dequeue
    msi_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("fill%0d_ready", i), 32'(wr_ready), 32'd1);
      wr_addr = M_BASE; wr_data = 32'(i); wr_valid = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("full_ready_low", 32'(wr_ready), 32'd0);
    check("full_head_id1", 32'(msi_id), 32'd1);
    wr_data = 32'd5;
    @(posedge clk); #1;
    @(negedge clk);
    check("full_hold_ready", 32'(wr_ready), 32'd0);
    check("full_hold_head", 32'(msi_id), 32'd1);
    msi_ready = 1'b1;
    @(posedge clk); #1;
    check("ready_rises_after_deq", 32'(wr_ready), 32'd1);
    check("head_after_deq", 32'(msi_id), 32'd2);
    @(negedge clk);
    msi_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    wr_valid = 1'b0;
    check("refull_ready_low", 32'(wr_ready), 32'd0);
    msi_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("drain_valid%0d", k), 32'(msi_valid), 32'd1);
      check($sformatf("drain_id%0d", k), 32'(msi_id), 32'(k));
      @(negedge clk);
    end
    check("drain_empty", 32'(msi_valid), 32'd0);

    // Reset with two entries queued
    msi_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wr_addr = M_BASE + 32'h1000; wr_data = 32'(10 + i); wr_valid = 1'b1;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    check("prerst_valid", 32'(msi_valid), 32'd1);
    check("prerst_drop", 32'(drop_cnt), 32'd8);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(msi_valid), 32'd0);
    check("rst_async_head", head_word(), 32'd0);
    check("rst_async_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    msi_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("postrst_valid%0d", c), 32'(msi_valid), 32'd0);
    end
    check("postrst_ready", 32'(wr_ready), 32'd1);

    // Randomized traffic against the queue model
    mq.delete();
    model_drop = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] off;
      bit ok;
      bit do_pop;
      bit do_push;
      int h, f, id;
      @(negedge clk);
      check("rnd_valid", 32'(msi_valid), 32'(mq.size() > 0));
      check("rnd_ready", 32'(wr_ready), 32'(mq.size() < FIFO_DEPTH));
      check("rnd_drop", 32'(drop_cnt), 32'(model_drop));
      check("rnd_head", head_word(),
            (mq.size() > 0) ? ((32'(mq[0].hart) << 16) | (32'(mq[0].file) << 8) | 32'(mq[0].id)) : 32'd0);
      case ($urandom_range(0, 3))
        0: off = 32'd0;
        1: off = 32'd4;
        2: off = 32'd8;
        default: off = $urandom_range(0, 4095);
      endcase
      case ($urandom_range(0, 3))
        0: a = M_BASE + 32'($urandom_range(0, 5)) * 32'h1000 + off;
        1: a = S_BASE + 32'($urandom_range(0, 9)) * 32'h1000 + off;
        2: a = M_BASE - 32'h1000 + off;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 2))
        0: d = 32'($urandom_range(0, 70));
        1: d = 32'($urandom_range(0, 70)) << 24;
        default: d = $urandom;
      endcase
      wr_addr = a; wr_data = d;
      wr_valid = ($urandom_range(0, 3) != 0);
      msi_ready = ($urandom_range(0, 2) == 0);
      do_pop = msi_ready && (mq.size() > 0);
      do_push = wr_valid && (mq.size() < FIFO_DEPTH);
      ref_decode(a, d, ok, h, f, id);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (ok) mq.push_back('{h, f, id});
        else if (model_drop < 65535) model_drop++;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
